// File: rtl/riscv_pkg.sv
// Core-wide RISC-V constants shared by decode, register file and writeback.
package riscv_pkg;

   localparam int XLEN         = 32;
   localparam int NB_REGS      = 5;
   localparam int NB_ARCH_REGS = 32;

   localparam int NB_WB_SRC = 3;
   localparam int WB_ALU    = 0;
   localparam int WB_LSU    = 1;
   localparam int WB_MDU    = 2;

   typedef logic [NB_REGS-1:0] reg_adr_t;

   function automatic logic [NB_ARCH_REGS-1:0] reg_onehot(input reg_adr_t adr);
      reg_onehot = NB_ARCH_REGS'(1) << adr;
   endfunction

endpackage

// File: rtl/wb_age_prio_arb.sv
// Fixed-priority arbiter where a requester that has lost AGE_MAX cycles in a row
// overrides the static order; the lowest-index aged requester wins.
module wb_age_prio_arb #(
   parameter int NB_SRC  = 3,
   parameter int AGE_MAX = 4,
   parameter int AGE_W   = $clog2(AGE_MAX+1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NB_SRC-1:0] valid_i,
   output logic [NB_SRC-1:0] grant_o
);

   localparam logic [AGE_W-1:0] AGE_LIM = AGE_W'(AGE_MAX);

   logic [AGE_W-1:0]  age_q [NB_SRC];
   logic [AGE_W-1:0]  age_d [NB_SRC];
   logic [NB_SRC-1:0] aged_s;
   logic [NB_SRC-1:0] aged_first_s;
   logic [NB_SRC-1:0] valid_first_s;
   logic [NB_SRC-1:0] grant_s;

   // Grant selection and next age values.
   always_comb begin
      for (int i = 0; i < NB_SRC; i++) begin
         aged_s[i] = valid_i[i] && (age_q[i] == AGE_LIM);
      end
      // x & -x isolates the lowest set bit, i.e. the highest-priority requester.
      aged_first_s  = aged_s & (~aged_s + NB_SRC'(1));
      valid_first_s = valid_i & (~valid_i + NB_SRC'(1));
      grant_s       = (|aged_s) ? aged_first_s : valid_first_s;
      for (int i = 0; i < NB_SRC; i++) begin
         age_d[i] = (grant_s[i] || !valid_i[i]) ? AGE_W'(0) :
                    (age_q[i] == AGE_LIM)       ? age_q[i]  :
                                                  age_q[i] + AGE_W'(1);
      end
   end

   // Age counter state.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NB_SRC; i++) begin
            age_q[i] <= AGE_W'(0);
         end
      end else begin
         age_q <= age_d;
      end
   end

   assign grant_o = grant_s;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: one registered write stage shared by the
// writeback sources, plus the busy scoreboard used by decode for RAW/WAW stalls.
module rf_wb_arbiter
   import riscv_pkg::*;
#(
   parameter int NB_SRC  = NB_WB_SRC,
   parameter int AGE_MAX = 4,
   parameter int AGE_W   = $clog2(AGE_MAX+1)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NB_SRC-1:0]         src_valid_i,
   output logic [NB_SRC-1:0]         src_ready_o,
   input  logic [NB_SRC*NB_REGS-1:0] src_adr_i,
   input  logic [NB_SRC*XLEN-1:0]    src_data_i,
   input  logic                      issue_valid_i,
   input  logic [NB_REGS-1:0]        issue_adr_i,
   input  logic [NB_REGS-1:0]        rs1_adr_i,
   input  logic [NB_REGS-1:0]        rs2_adr_i,
   output logic                      rs1_busy_o,
   output logic                      rs2_busy_o,
   output logic                      rd_busy_o,
   output logic                      write_valid_o,
   output logic [NB_REGS-1:0]        write_adr_o,
   output logic [XLEN-1:0]           write_data_o
);

   logic [NB_SRC-1:0]       grant_s;
   logic                    xfer_s;
   logic [NB_REGS-1:0]      sel_adr_s;
   logic [XLEN-1:0]         sel_data_s;
   logic [NB_ARCH_REGS-1:0] clr_mask_s;
   logic [NB_ARCH_REGS-1:0] set_mask_s;

   logic                    write_valid_q, write_valid_d;
   logic [NB_REGS-1:0]      write_adr_q, write_adr_d;
   logic [XLEN-1:0]         write_data_q, write_data_d;
   logic [NB_ARCH_REGS-1:0] busy_q, busy_d;

   wb_age_prio_arb #(
      .NB_SRC  (NB_SRC),
      .AGE_MAX (AGE_MAX),
      .AGE_W   (AGE_W)
   ) u_arb (
      .clk     (clk),
      .reset   (reset),
      .valid_i (src_valid_i),
      .grant_o (grant_s)
   );

   // Granted-source mux and next output-stage values.
   always_comb begin
      sel_adr_s  = '0;
      sel_data_s = '0;
      for (int i = 0; i < NB_SRC; i++) begin
         sel_adr_s  = sel_adr_s  | (grant_s[i] ? src_adr_i[i*NB_REGS +: NB_REGS] : NB_REGS'(0));
         sel_data_s = sel_data_s | (grant_s[i] ? src_data_i[i*XLEN +: XLEN]      : XLEN'(0));
      end
      xfer_s        = |grant_s;
      // x0 writes complete the handshake but never reach the register file.
      write_valid_d = xfer_s && (sel_adr_s != NB_REGS'(0));
      write_adr_d   = xfer_s ? sel_adr_s  : write_adr_q;
      write_data_d  = xfer_s ? sel_data_s : write_data_q;
   end

   // Scoreboard next state: a new producer's set overrides a same-cycle clear.
   always_comb begin
      clr_mask_s = write_valid_q ? reg_onehot(write_adr_q) : NB_ARCH_REGS'(0);
      set_mask_s = (issue_valid_i && (issue_adr_i != NB_REGS'(0))) ?
                   reg_onehot(issue_adr_i) : NB_ARCH_REGS'(0);
      busy_d     = ((busy_q & ~clr_mask_s) | set_mask_s) & ~NB_ARCH_REGS'(1);
   end

   // Output stage and scoreboard state.
   always_ff @(posedge clk) begin
      if (reset) begin
         write_valid_q <= 1'b0;
         write_adr_q   <= NB_REGS'(0);
         write_data_q  <= XLEN'(0);
         busy_q        <= NB_ARCH_REGS'(0);
      end else begin
         write_valid_q <= write_valid_d;
         write_adr_q   <= write_adr_d;
         write_data_q  <= write_data_d;
         busy_q        <= busy_d;
      end
   end

   assign src_ready_o   = grant_s;
   assign write_valid_o = write_valid_q;
   assign write_adr_o   = write_adr_q;
   assign write_data_o  = write_data_q;
   assign rs1_busy_o    = busy_q[rs1_adr_i];
   assign rs2_busy_o    = busy_q[rs2_adr_i];
   assign rd_busy_o     = busy_q[issue_adr_i];

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: expected register-file writes are queued when
// a request is driven and compared when the output stage presents them.
module tb_rf_wb_arbiter;
   import riscv_pkg::*;

   typedef struct {
      logic        v;
      logic [4:0]  adr;
      logic [31:0] data;
   } wr_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  v;
   logic [4:0]  a [3];
   logic [31:0] d [3];
   logic        issue_valid;
   logic [4:0]  issue_adr, rs1_adr, rs2_adr;

   logic [2:0]  src_valid, src_ready;
   logic [14:0] src_adr;
   logic [95:0] src_data;
   logic        rs1_busy, rs2_busy, rd_busy;
   logic        write_valid;
   logic [4:0]  write_adr;
   logic [31:0] write_data;

   int          n_cmp = 0;
   int          n_bad = 0;
   wr_t         exp_q [$];
   logic [4:0]  last_adr;
   logic [31:0] last_data;

   always #5 clk = ~clk;

   assign src_valid = v;
   assign src_adr   = {a[2], a[1], a[0]};
   assign src_data  = {d[2], d[1], d[0]};

   rf_wb_arbiter dut (
      .clk           (clk),
      .reset         (reset),
      .src_valid_i   (src_valid),
      .src_ready_o   (src_ready),
      .src_adr_i     (src_adr),
      .src_data_i    (src_data),
      .issue_valid_i (issue_valid),
      .issue_adr_i   (issue_adr),
      .rs1_adr_i     (rs1_adr),
      .rs2_adr_i     (rs2_adr),
      .rs1_busy_o    (rs1_busy),
      .rs2_busy_o    (rs2_busy),
      .rd_busy_o     (rd_busy),
      .write_valid_o (write_valid),
      .write_adr_o   (write_adr),
      .write_data_o  (write_data)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: check the grant, queue the expected write, advance, check the write.
   task automatic cycle(input string tag, input logic [2:0] exp_grant);
      wr_t e;
      wr_t got;
      #1;
      chk({tag, ".ready"}, {29'd0, src_ready}, {29'd0, exp_grant});
      e.v = 1'b0;
      e.adr = last_adr;
      e.data = last_data;
      for (int i = 0; i < 3; i++) begin
         if (exp_grant[i]) begin
            e.v = (a[i] != 5'd0);
            e.adr = a[i];
            e.data = d[i];
         end
      end
      last_adr = e.adr;
      last_data = e.data;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         chk({tag, ".queue_empty"}, 32'd0, 32'd1);
      end else begin
         got = exp_q.pop_front();
         chk({tag, ".wvalid"}, {31'd0, write_valid}, {31'd0, got.v});
         chk({tag, ".wadr"}, {27'd0, write_adr}, {27'd0, got.adr});
         chk({tag, ".wdata"}, write_data, got.data);
      end
   endtask

   initial begin
      reset = 1'b1;
      v = 3'b000;
      for (int i = 0; i < 3; i++) begin
         a[i] = 5'd0;
         d[i] = 32'd0;
      end
      issue_valid = 1'b0;
      issue_adr = 5'd0;
      rs1_adr = 5'd5;
      rs2_adr = 5'd5;
      last_adr = 5'd0;
      last_data = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.wvalid", {31'd0, write_valid}, 32'd0);
      chk("rst.wadr", {27'd0, write_adr}, 32'd0);
      chk("rst.wdata", write_data, 32'd0);
      chk("rst.busy5", {31'd0, rs1_busy}, 32'd0);
      reset = 1'b0;

      // Issue to x5, then ALU writes it back.
      issue_valid = 1'b1;
      issue_adr = 5'd5;
      #1;
      chk("iss5.rd_busy_before", {31'd0, rd_busy}, 32'd0);
      cycle("iss5", 3'b000);
      issue_valid = 1'b0;
      chk("iss5.rs1_busy", {31'd0, rs1_busy}, 32'd1);
      v = 3'b001;
      a[WB_ALU] = 5'd5;
      d[WB_ALU] = 32'hDEAD_BEEF;
      cycle("alu5", 3'b001);
      chk("alu5.busy_still", {31'd0, rs1_busy}, 32'd1);
      v = 3'b000;
      cycle("idle1", 3'b000);
      chk("alu5.busy_cleared", {31'd0, rs1_busy}, 32'd0);

      // Static priority ALU over LSU.
      v = 3'b011;
      a[WB_ALU] = 5'd3;
      d[WB_ALU] = 32'h0000_0033;
      a[WB_LSU] = 5'd4;
      d[WB_LSU] = 32'h0000_0044;
      cycle("prio0", 3'b001);
      cycle("prio1", 3'b001);
      v = 3'b010;
      cycle("prio2", 3'b010);
      v = 3'b000;
      cycle("idle2", 3'b000);

      // Aging: MDU loses four cycles then is forced through.
      v = 3'b101;
      a[WB_ALU] = 5'd1;
      d[WB_ALU] = 32'h0000_0011;
      a[WB_MDU] = 5'd2;
      d[WB_MDU] = 32'h0000_0022;
      cycle("age0", 3'b001);
      cycle("age1", 3'b001);
      cycle("age2", 3'b001);
      cycle("age3", 3'b001);
      cycle("age4", 3'b100);
      v = 3'b001;
      cycle("age5", 3'b001);
      v = 3'b000;
      cycle("idle3", 3'b000);

      // x0 write and issue to x0.
      v = 3'b010;
      a[WB_LSU] = 5'd0;
      d[WB_LSU] = 32'h0000_1234;
      issue_valid = 1'b1;
      issue_adr = 5'd0;
      cycle("x0", 3'b010);
      v = 3'b000;
      issue_valid = 1'b0;
      rs1_adr = 5'd0;
      #1;
      chk("x0.rs1_busy", {31'd0, rs1_busy}, 32'd0);
      chk("x0.rd_busy", {31'd0, rd_busy}, 32'd0);
      chk("x0.busy5", {31'd0, rs2_busy}, 32'd0);

      // Set/clear collision on x7.
      issue_valid = 1'b1;
      issue_adr = 5'd7;
      cycle("iss7", 3'b000);
      issue_valid = 1'b0;
      v = 3'b001;
      a[WB_ALU] = 5'd7;
      d[WB_ALU] = 32'h0000_0077;
      cycle("alu7", 3'b001);
      v = 3'b000;
      issue_valid = 1'b1;
      issue_adr = 5'd7;
      #1;
      chk("coll.rd_busy_before", {31'd0, rd_busy}, 32'd1);
      cycle("coll", 3'b000);
      issue_valid = 1'b0;
      rs1_adr = 5'd7;
      #1;
      chk("coll.busy_kept", {31'd0, rs1_busy}, 32'd1);
      cycle("coll_idle", 3'b000);
      chk("coll.busy_held", {31'd0, rs1_busy}, 32'd1);
      v = 3'b001;
      cycle("alu7b", 3'b001);
      v = 3'b000;
      cycle("idle4", 3'b000);
      chk("coll.busy_cleared", {31'd0, rs1_busy}, 32'd0);

      // Reset mid-operation: busy = 0xA0, LSU age saturated, write pending.
      rs1_adr = 5'd5;
      rs2_adr = 5'd7;
      v = 3'b011;
      a[WB_ALU] = 5'd9;
      d[WB_ALU] = 32'h0000_0099;
      a[WB_LSU] = 5'd10;
      d[WB_LSU] = 32'h0000_00AA;
      issue_valid = 1'b1;
      issue_adr = 5'd5;
      cycle("pre0", 3'b001);
      issue_adr = 5'd7;
      cycle("pre1", 3'b001);
      issue_valid = 1'b0;
      cycle("pre2", 3'b001);
      cycle("pre3", 3'b001);
      chk("pre.busy5", {31'd0, rs1_busy}, 32'd1);
      chk("pre.busy7", {31'd0, rs2_busy}, 32'd1);
      reset = 1'b1;
      v = 3'b000;
      @(posedge clk);
      #1;
      reset = 1'b0;
      last_adr = 5'd0;
      last_data = 32'd0;
      chk("mrst.wvalid", {31'd0, write_valid}, 32'd0);
      chk("mrst.wadr", {27'd0, write_adr}, 32'd0);
      chk("mrst.wdata", write_data, 32'd0);
      chk("mrst.busy5", {31'd0, rs1_busy}, 32'd0);
      chk("mrst.busy7", {31'd0, rs2_busy}, 32'd0);
      v = 3'b011;
      cycle("post0", 3'b001);
      v = 3'b000;
      cycle("post_idle", 3'b000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
